pc_redirect_unit: RTL

- Fetch-side consumer of the ID-stage branch decision (take_branch, branch_target).
- Owns the program counter and drives instruction-fetch requests to the instruction memory.
- Applies each taken branch exactly once, even when the decision is held for several cycles by a stall or instruction-memory backpressure.
- Generates the IF/ID flush, traps misaligned targets and counts redirects.

---
 rtl/pc_redirect_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
// Fetch-side PC owner: applies each taken ID-stage branch exactly once,
// flushes IF/ID on redirect, traps misaligned targets and counts redirects.
module pc_redirect_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] TRAP_VEC = 64'h100,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             take_branch,
    input  logic [63:0]      branch_target,
    output logic [63:0]      pc_out,
    output logic             pc_valid,
    output logic             flush_if_id,
    output logic             redirect_pending,
    output logic             misalign_err,
    output logic [CNT_W-1:0] branch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] pending_target;
    logic        can_go;
    logic        fire;
    logic [63:0] fire_target;
    logic        fire_misaligned;
    logic [63:0] eff_target;

    assign can_go = pc_valid & fetch_ready & ~stall & ~reset;

    // A held branch fires from the latched target; take_branch is ignored in HOLD.
    always_comb begin
        fire        = 1'b0;
        fire_target = branch_target;
        unique case (state)
            RUN: begin
                fire        = take_branch & can_go;
                fire_target = branch_target;
            end
            HOLD: begin
                fire        = can_go;
                fire_target = pending_target;
            end
            default: begin
                fire        = 1'b0;
                fire_target = branch_target;
            end
        endcase
    end

    assign fire_misaligned = fire_target[1:0] != 2'b00;
    assign eff_target      = fire_misaligned ? TRAP_VEC : fire_target;
    assign flush_if_id     = fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= BOOT;
            pc_out           <= RESET_PC;
            pending_target   <= 64'h0;
            pc_valid         <= 1'b0;
            redirect_pending <= 1'b0;
            misalign_err     <= 1'b0;
            branch_count     <= '0;
        end else begin
            misalign_err <= 1'b0;
            unique case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (fire) begin
                        pc_out       <= eff_target;
                        misalign_err <= fire_misaligned;
                        if (branch_count != '1)
                            branch_count <= branch_count + 1'b1;
                    end else if (take_branch) begin
                        pending_target   <= branch_target;
                        redirect_pending <= 1'b1;
                        state            <= HOLD;
                    end else if (can_go) begin
                        pc_out <= pc_out + 64'd4;
                    end
                end
                HOLD: begin
                    if (fire) begin
                        pc_out           <= eff_target;
                        misalign_err     <= fire_misaligned;
                        redirect_pending <= 1'b0;
                        state            <= RUN;
                        if (branch_count != '1)
                            branch_count <= branch_count + 1'b1;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
